sorted_unloader: RTL and testbench
==================================

SORTED_UNLOADER -- requirements
Module: sorted_unloader

Interface
REQ-001 SHALL have parameter NUMBER_WIDTH, default 10, bit width of one word.
REQ-002 SHALL have parameter NUMBERS_AMOUNT, default 10, words per vector; legal range 2..256.
REQ-003 SHALL have port clk_i  input  1  single clock; all logic rising-edge.
REQ-004 SHALL have port rst_n_i  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port data_i  input  [NUMBERS_AMOUNT-1:0][NUMBER_WIDTH-1:0]  sorted vector from the sorting network, word 0 smallest.
REQ-006 SHALL have port data_valid_i  input  1  one-cycle qualifier for data_i; no backpressure upstream.
REQ-007 SHALL have port data_o  output  NUMBER_WIDTH  current serial word.
REQ-008 SHALL have port data_valid_o  output  1  data_o valid.
REQ-009 SHALL have port data_ready_i  input  1  downstream accepts data_o.
REQ-010 SHALL have port data_last_o  output  1  data_o is the final word of its vector.
REQ-011 SHALL have port overflow_o  output  1  sticky: at least one vector dropped.
REQ-012 SHALL have port drop_cnt_o  output  16  saturating count of dropped vectors.

Function
REQ-013 SHALL hold two vector registers: ACTIVE (streaming) and PENDING (waiting), each with a full flag.
REQ-014 SHALL use states IDLE (ACTIVE empty) and STREAM (ACTIVE full); IDLE->STREAM on load, STREAM->IDLE on last-word transfer with PENDING empty and no data_valid_i.
REQ-015 SHALL count a transfer only when data_valid_o && data_ready_i at a rising edge.
REQ-016 SHALL drive data_valid_o = 1 exactly in STREAM; data_o and data_last_o SHALL stay stable while data_valid_o && !data_ready_i.
REQ-017 SHALL keep index counter idx, width max(1,$clog2(NUMBERS_AMOUNT)), data_o = ACTIVE[idx]; idx resets to the start index on every ACTIVE load.
REQ-018 SHALL assert data_last_o when idx equals the end index and data_valid_o = 1.
REQ-019 SHALL present a vector accepted at edge t on data_o starting after edge t (latency one cycle) when ACTIVE was empty.
REQ-020 On data_valid_i: ACTIVE free (or freeing by last-word transfer this cycle) and PENDING empty -> load ACTIVE.
REQ-021 On data_valid_i otherwise, PENDING empty (or moving to ACTIVE this cycle) -> load PENDING.
REQ-022 On data_valid_i with both full and no last-word transfer this cycle -> drop vector, set overflow_o, drop_cnt_o += 1 saturating at 16'hFFFF.
REQ-023 On last-word transfer with PENDING full SHALL move PENDING to ACTIVE in the same edge, no bubble cycle on data_valid_o.
REQ-024 Sustained throughput SHALL be one word per cycle with data_ready_i held high.
REQ-025 SHALL never reorder or truncate a vector; vectors emerge in acceptance order.

Reset
REQ-026 On rst_n_i low, asynchronously: state IDLE, both full flags 0, idx start, data_valid_o 0, data_last_o 0, data_o 0, overflow_o 0, drop_cnt_o 0, vector registers 0.
REQ-027 Reset mid-stream SHALL discard ACTIVE and PENDING; first vector after release starts at the start index.
REQ-028 overflow_o and drop_cnt_o SHALL clear only by reset.

Configuration
REQ-029 Macro SORTED_UNLOADER_DESC_EN defined: start index NUMBERS_AMOUNT-1, idx decrements, end index 0 (largest first).
REQ-030 Macro undefined: start index 0, idx increments, end index NUMBERS_AMOUNT-1 (smallest first).

Verification (NUMBER_WIDTH=8, NUMBERS_AMOUNT=4, ascending unless noted)
REQ-031 Vector {3,7,9,12} (word0=3), ready=1 -> data_o 3,7,9,12 on four consecutive cycles from the cycle after load, data_last_o only with 12.
REQ-032 Same vector, ready toggling 1,0,0,1,... -> each word held stable while ready=0, no word skipped or repeated.
REQ-033 Three vectors on consecutive cycles, ready=0 for 10 cycles then 1 -> first two streamed in order (8 words), third dropped, overflow_o=1, drop_cnt_o=1.
REQ-034 Second vector arriving in the cycle of first vector's last-word transfer, ready=1 -> 8 words back-to-back, data_valid_o never low between, no drop.
REQ-035 rst_n_i low for one cycle mid-stream (after word 2) -> data_valid_o, overflow_o, drop_cnt_o 0 immediately; next vector streams from word0.
REQ-036 SORTED_UNLOADER_DESC_EN defined, vector {3,7,9,12} -> data_o 12,9,7,3, data_last_o with 3.

Source files
------------

// File: rtl/sorted_unloader.sv
// sorted_unloader: double-buffered serializer for sorted vectors.
// Define SORTED_UNLOADER_DESC_EN to emit largest word first.
module sorted_unloader #(
    parameter int NUMBER_WIDTH   = 10,
    parameter int NUMBERS_AMOUNT = 10
) (
    input  logic                                        clk_i,
    input  logic                                        rst_n_i,
    input  logic [NUMBERS_AMOUNT-1:0][NUMBER_WIDTH-1:0] data_i,
    input  logic                                        data_valid_i,
    output logic [NUMBER_WIDTH-1:0]                     data_o,
    output logic                                        data_valid_o,
    input  logic                                        data_ready_i,
    output logic                                        data_last_o,
    output logic                                        overflow_o,
    output logic [15:0]                                 drop_cnt_o
);

    localparam int IW = ($clog2(NUMBERS_AMOUNT) > 1) ? $clog2(NUMBERS_AMOUNT) : 1;

`ifdef SORTED_UNLOADER_DESC_EN
    localparam logic [IW-1:0] START = IW'(NUMBERS_AMOUNT - 1);
    localparam logic [IW-1:0] ENDI  = '0;
`else
    localparam logic [IW-1:0] START = '0;
    localparam logic [IW-1:0] ENDI  = IW'(NUMBERS_AMOUNT - 1);
`endif

    typedef enum logic {
        IDLE,
        STREAM
    } state_t;

    typedef logic [NUMBERS_AMOUNT-1:0][NUMBER_WIDTH-1:0] vec_t;

    state_t        state_q;
    state_t        state_d;
    vec_t          act_q;
    vec_t          pend_q;
    logic          act_full;
    logic          pend_full_q;
    logic [IW-1:0] idx_q;
    logic [IW-1:0] idx_step;
    logic          ovf_q;
    logic [15:0]   drop_q;

    logic          xfer;
    logic          last_xfer;
    logic          act_free;
    logic          load_act;
    logic          move_pend;
    logic          load_pend;
    logic          drop;

    // ACTIVE is full exactly while streaming
    assign act_full  = (state_q == STREAM);
    assign xfer      = data_valid_o & data_ready_i;
    assign last_xfer = xfer & (idx_q == ENDI);
    assign act_free  = ~act_full | last_xfer;
    assign move_pend = last_xfer & pend_full_q;
    assign load_act  = data_valid_i & act_free & ~pend_full_q;
    assign load_pend = data_valid_i & ~load_act & (~pend_full_q | move_pend);
    assign drop      = data_valid_i & ~load_act & ~load_pend;

`ifdef SORTED_UNLOADER_DESC_EN
    assign idx_step = idx_q - IW'(1);
`else
    assign idx_step = idx_q + IW'(1);
`endif

    // State register
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: leave STREAM only when nothing refills ACTIVE
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (load_act) begin
                    state_d = STREAM;
                end
            end
            STREAM: begin
                if (last_xfer && !move_pend && !load_act) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output decode: word select and last flag while streaming
    always_comb begin
        data_valid_o = 1'b0;
        data_last_o  = 1'b0;
        data_o       = '0;
        if (state_q == STREAM) begin
            data_valid_o = 1'b1;
            data_last_o  = (idx_q == ENDI);
            data_o       = act_q[idx_q];
        end
    end

    // ACTIVE vector: fresh input or promoted PENDING
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            act_q <= '0;
        end else if (load_act) begin
            act_q <= data_i;
        end else if (move_pend) begin
            act_q <= pend_q;
        end
    end

    // PENDING vector and its full flag
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            pend_q      <= '0;
            pend_full_q <= 1'b0;
        end else begin
            if (load_pend) begin
                pend_q <= data_i;
            end
            if (load_pend) begin
                pend_full_q <= 1'b1;
            end else if (move_pend) begin
                pend_full_q <= 1'b0;
            end
        end
    end

    // Word index: rewinds on every ACTIVE load, steps on transfer
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            idx_q <= START;
        end else if (load_act || move_pend) begin
            idx_q <= START;
        end else if (xfer) begin
            idx_q <= idx_step;
        end
    end

    // Sticky overflow and saturating drop counter
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            ovf_q  <= 1'b0;
            drop_q <= '0;
        end else if (drop) begin
            ovf_q <= 1'b1;
            if (drop_q != 16'hFFFF) begin
                drop_q <= drop_q + 16'd1;
            end
        end
    end

    assign overflow_o = ovf_q;
    assign drop_cnt_o = drop_q;

endmodule

// File: tb/tb_sorted_unloader.sv
// tb_sorted_unloader: directed checks of sorted_unloader.
// Expected order follows SORTED_UNLOADER_DESC_EN when defined.
module tb_sorted_unloader;

    typedef logic [3:0][7:0] vec_t;

    logic        clk_i;
    logic        rst_n_i;
    vec_t        data_i;
    logic        data_valid_i;
    logic [7:0]  data_o;
    logic        data_valid_o;
    logic        data_ready_i;
    logic        data_last_o;
    logic        overflow_o;
    logic [15:0] drop_cnt_o;

    int n_cmp;
    int n_err;

    sorted_unloader #(
        .NUMBER_WIDTH  (8),
        .NUMBERS_AMOUNT(4)
    ) dut (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .data_i      (data_i),
        .data_valid_i(data_valid_i),
        .data_o      (data_o),
        .data_valid_o(data_valid_o),
        .data_ready_i(data_ready_i),
        .data_last_o (data_last_o),
        .overflow_o  (overflow_o),
        .drop_cnt_o  (drop_cnt_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // k-th word in emission order
    function automatic logic [7:0] ew(vec_t v, int k);
`ifdef SORTED_UNLOADER_DESC_EN
        return v[3-k];
`else
        return v[k];
`endif
    endfunction

    function automatic vec_t mk(int a, int b, int c, int d);
        vec_t v;
        v[0] = 8'(a);
        v[1] = 8'(b);
        v[2] = 8'(c);
        v[3] = 8'(d);
        return v;
    endfunction

    task automatic test_reset();
        rst_n_i      = 1'b0;
        data_valid_i = 1'b0;
        data_ready_i = 1'b0;
        data_i       = '0;
        repeat (2) @(negedge clk_i);
        n_cmp++;
        if (data_valid_o !== 1'b0) begin
            n_err++;
            $display("FAIL rst_valid: got %0b want 0", data_valid_o);
        end
        n_cmp++;
        if (data_last_o !== 1'b0) begin
            n_err++;
            $display("FAIL rst_last: got %0b want 0", data_last_o);
        end
        n_cmp++;
        if (data_o !== 8'd0) begin
            n_err++;
            $display("FAIL rst_data: got %0d want 0", data_o);
        end
        n_cmp++;
        if (overflow_o !== 1'b0) begin
            n_err++;
            $display("FAIL rst_ovf: got %0b want 0", overflow_o);
        end
        n_cmp++;
        if (drop_cnt_o !== 16'd0) begin
            n_err++;
            $display("FAIL rst_drop: got %0d want 0", drop_cnt_o);
        end
        rst_n_i = 1'b1;
        @(negedge clk_i);
    endtask

    task automatic test_stream();
        vec_t va;
        va = mk(3, 7, 9, 12);
        @(negedge clk_i);
        data_i       = va;
        data_valid_i = 1'b1;
        data_ready_i = 1'b1;
        @(negedge clk_i);
        data_valid_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) @(negedge clk_i);
            n_cmp++;
            if (data_valid_o !== 1'b1 || data_o !== ew(va, k)
                || data_last_o !== (k == 3)) begin
                n_err++;
                $display("FAIL stream_w%0d: got v=%0b d=%0d l=%0b want v=1 d=%0d l=%0b",
                         k, data_valid_o, data_o, data_last_o, ew(va, k), (k == 3));
            end
        end
        @(negedge clk_i);
        n_cmp++;
        if (data_valid_o !== 1'b0) begin
            n_err++;
            $display("FAIL stream_end: got valid %0b want 0", data_valid_o);
        end
    endtask

    task automatic test_ready_toggle();
        vec_t va;
        int   k;
        va = mk(3, 7, 9, 12);
        k  = 0;
        @(negedge clk_i);
        data_i       = va;
        data_valid_i = 1'b1;
        data_ready_i = 1'b0;
        for (int c = 0; c < 30 && k < 4; c++) begin
            @(negedge clk_i);
            data_valid_i = 1'b0;
            data_ready_i = ((c % 3) == 0);
            n_cmp++;
            if (data_valid_o !== 1'b1 || data_o !== ew(va, k)
                || data_last_o !== (k == 3)) begin
                n_err++;
                $display("FAIL toggle_c%0d: got v=%0b d=%0d l=%0b want v=1 d=%0d l=%0b",
                         c, data_valid_o, data_o, data_last_o, ew(va, k), (k == 3));
            end
            if (data_ready_i) k++;
        end
        n_cmp++;
        if (k != 4) begin
            n_err++;
            $display("FAIL toggle_count: got %0d words want 4", k);
        end
        @(negedge clk_i);
        data_ready_i = 1'b1;
        n_cmp++;
        if (data_valid_o !== 1'b0) begin
            n_err++;
            $display("FAIL toggle_end: got valid %0b want 0", data_valid_o);
        end
    endtask

    task automatic test_overflow();
        vec_t va;
        vec_t vb;
        vec_t vc;
        vec_t v;
        va = mk(1, 2, 3, 4);
        vb = mk(10, 20, 30, 40);
        vc = mk(50, 60, 70, 80);
        @(negedge clk_i);
        data_ready_i = 1'b0;
        data_i       = va;
        data_valid_i = 1'b1;
        @(negedge clk_i);
        data_i = vb;
        @(negedge clk_i);
        data_i = vc;
        @(negedge clk_i);
        data_valid_i = 1'b0;
        repeat (8) @(negedge clk_i);
        n_cmp++;
        if (overflow_o !== 1'b1) begin
            n_err++;
            $display("FAIL ovf_flag: got %0b want 1", overflow_o);
        end
        n_cmp++;
        if (drop_cnt_o !== 16'd1) begin
            n_err++;
            $display("FAIL ovf_cnt: got %0d want 1", drop_cnt_o);
        end
        n_cmp++;
        if (data_valid_o !== 1'b1 || data_o !== ew(va, 0)) begin
            n_err++;
            $display("FAIL ovf_hold: got v=%0b d=%0d want v=1 d=%0d",
                     data_valid_o, data_o, ew(va, 0));
        end
        for (int k = 0; k < 8; k++) begin
            data_ready_i = 1'b1;
            v = (k < 4) ? va : vb;
            n_cmp++;
            if (data_valid_o !== 1'b1 || data_o !== ew(v, k % 4)
                || data_last_o !== ((k % 4) == 3)) begin
                n_err++;
                $display("FAIL ovf_w%0d: got v=%0b d=%0d l=%0b want v=1 d=%0d l=%0b",
                         k, data_valid_o, data_o, data_last_o, ew(v, k % 4),
                         ((k % 4) == 3));
            end
            @(negedge clk_i);
        end
        n_cmp++;
        if (data_valid_o !== 1'b0) begin
            n_err++;
            $display("FAIL ovf_end: got valid %0b want 0", data_valid_o);
        end
    endtask

    task automatic test_back_to_back();
        vec_t vd;
        vec_t ve;
        vec_t v;
        vd = mk(5, 6, 8, 11);
        ve = mk(100, 101, 150, 255);
        data_ready_i = 1'b1;
        data_i       = vd;
        data_valid_i = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk_i);
            data_valid_i = (k == 3);
            data_i       = ve;
            v = (k < 4) ? vd : ve;
            n_cmp++;
            if (data_valid_o !== 1'b1 || data_o !== ew(v, k % 4)
                || data_last_o !== ((k % 4) == 3)) begin
                n_err++;
                $display("FAIL b2b_w%0d: got v=%0b d=%0d l=%0b want v=1 d=%0d l=%0b",
                         k, data_valid_o, data_o, data_last_o, ew(v, k % 4),
                         ((k % 4) == 3));
            end
        end
        @(negedge clk_i);
        data_valid_i = 1'b0;
        n_cmp++;
        if (data_valid_o !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_end: got valid %0b want 0", data_valid_o);
        end
        n_cmp++;
        if (drop_cnt_o !== 16'd1) begin
            n_err++;
            $display("FAIL b2b_drop: got %0d want 1", drop_cnt_o);
        end
    endtask

    task automatic test_reset_mid();
        vec_t vf;
        vec_t vh;
        vec_t vg;
        vf = mk(2, 4, 6, 8);
        vh = mk(90, 91, 92, 93);
        vg = mk(13, 17, 19, 23);
        data_ready_i = 1'b1;
        data_i       = vf;
        data_valid_i = 1'b1;
        @(negedge clk_i);
        data_i = vh;
        n_cmp++;
        if (data_o !== ew(vf, 0)) begin
            n_err++;
            $display("FAIL mid_w0: got %0d want %0d", data_o, ew(vf, 0));
        end
        @(negedge clk_i);
        data_valid_i = 1'b0;
        n_cmp++;
        if (data_o !== ew(vf, 1)) begin
            n_err++;
            $display("FAIL mid_w1: got %0d want %0d", data_o, ew(vf, 1));
        end
        @(negedge clk_i);
        rst_n_i = 1'b0;
        #1;
        n_cmp++;
        if (data_valid_o !== 1'b0 || overflow_o !== 1'b0
            || drop_cnt_o !== 16'd0 || data_last_o !== 1'b0) begin
            n_err++;
            $display("FAIL mid_rst: got v=%0b o=%0b c=%0d l=%0b want all 0",
                     data_valid_o, overflow_o, drop_cnt_o, data_last_o);
        end
        @(negedge clk_i);
        rst_n_i = 1'b1;
        @(negedge clk_i);
        data_i       = vg;
        data_valid_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk_i);
            data_valid_i = 1'b0;
            n_cmp++;
            if (data_valid_o !== 1'b1 || data_o !== ew(vg, k)
                || data_last_o !== (k == 3)) begin
                n_err++;
                $display("FAIL mid_g%0d: got v=%0b d=%0d l=%0b want v=1 d=%0d l=%0b",
                         k, data_valid_o, data_o, data_last_o, ew(vg, k), (k == 3));
            end
        end
        @(negedge clk_i);
        n_cmp++;
        if (data_valid_o !== 1'b0) begin
            n_err++;
            $display("FAIL mid_end: got valid %0b want 0", data_valid_o);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_stream();
        test_ready_toggle();
        test_overflow();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
